// File: rtl/user_rc_decoder.sv
`default_nettype none
// ============================================================================
// Module   : user_rc_decoder
// Brief    : Requester Completion decoder. Realigns dword-aligned RC payload
//            onto a 128-bit read port, tracks outstanding MemRd tags and
//            reports malformed or unexpected completions.
// Revision : 1.0  initial release
// ============================================================================
module user_rc_decoder #(
    parameter int C_DATA_WIDTH        = 128,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RC_TUSER_WIDTH = 75
) (
    input  logic                           user_clk,
    input  logic                           reset,
    input  logic [C_DATA_WIDTH-1:0]        m_axis_rc_tdata,
    input  logic [KEEP_WIDTH-1:0]          m_axis_rc_tkeep,
    input  logic [AXI4_RC_TUSER_WIDTH-1:0] m_axis_rc_tuser,
    input  logic                           m_axis_rc_tlast,
    input  logic                           m_axis_rc_tvalid,
    output logic                           m_axis_rc_tready,
    input  logic                           req_issue_valid,
    input  logic [7:0]                     req_issue_tag,
    output logic                           rd_valid,
    output logic [127:0]                   rd_data,
    output logic [3:0]                     rd_keep,
    output logic                           rd_last,
    output logic [7:0]                     rd_tag,
    output logic                           cpl_err_valid,
    output logic [7:0]                     cpl_err_tag,
    output logic [3:0]                     cpl_err_code,
    output logic [8:0]                     outstanding_cnt,
    output logic                           idle
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    localparam logic [3:0] c_ERR_STATUS  = 4'd1;
    localparam logic [3:0] c_ERR_POISON  = 4'd2;
    localparam logic [3:0] c_ERR_CODE    = 4'd3;
    localparam logic [3:0] c_ERR_TAG     = 4'd4;
    localparam logic [3:0] c_ERR_LENGTH  = 4'd5;
    localparam logic [3:0] c_ERR_DISCONT = 4'd6;
    localparam logic [3:0] c_ERR_DUP     = 4'd7;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_held;
    logic [10:0]    r_rem;
    logic [7:0]     r_cur_tag;
    logic           r_cur_req_cpl;
    logic [255:0]   r_bitmap;
    logic [8:0]     r_cnt;
    logic           r_rd_valid;
    logic [127:0]   r_rd_data;
    logic [3:0]     r_rd_keep;
    logic           r_rd_last;
    logic [7:0]     r_rd_tag;
    logic           r_err_valid;
    logic [7:0]     r_err_tag;
    logic [3:0]     r_err_code;

    logic           w_beat;
    logic [10:0]    w_desc_dw_cnt;
    logic [7:0]     w_desc_tag;
    logic           w_desc_req_cpl;
    logic [3:0]     w_desc_code;
    logic           w_rem_ge4;
    logic           w_rem_le4;
    logic [3:0]     w_keep;
    logic [10:0]    w_take;

    logic           w_load_desc;
    logic           w_data_step;
    logic           w_out_valid;
    logic [127:0]   w_out_data;
    logic [3:0]     w_out_keep;
    logic           w_out_last;
    logic           w_dec_err;
    logic [7:0]     w_dec_err_tag;
    logic [3:0]     w_dec_err_code;
    logic           w_clr;
    logic [7:0]     w_clr_tag;

    logic           w_dup;
    logic           w_set;
    logic           w_clr_eff;
    logic           w_inc;
    logic           w_unused_sideband;

    assign w_unused_sideband = ^{m_axis_rc_tkeep,
                                 m_axis_rc_tuser[AXI4_RC_TUSER_WIDTH-1:43],
                                 m_axis_rc_tuser[41:0]};

    assign m_axis_rc_tready = (r_state != ST_FLUSH);
    assign w_beat           = m_axis_rc_tvalid && m_axis_rc_tready;

    assign w_desc_dw_cnt  = m_axis_rc_tdata[42:32];
    assign w_desc_tag     = m_axis_rc_tdata[71:64];
    assign w_desc_req_cpl = m_axis_rc_tdata[30];

    always_comb begin
        if (!r_bitmap[w_desc_tag])
            w_desc_code = c_ERR_TAG;
        else if (m_axis_rc_tdata[45:43] != 3'd0)
            w_desc_code = c_ERR_STATUS;
        else if (m_axis_rc_tdata[46])
            w_desc_code = c_ERR_POISON;
        else if (m_axis_rc_tdata[15:12] != 4'd0)
            w_desc_code = c_ERR_CODE;
        else if (m_axis_rc_tuser[42])
            w_desc_code = c_ERR_DISCONT;
        else
            w_desc_code = 4'd0;
    end

    assign w_rem_ge4 = (r_rem >= 11'd4);
    assign w_rem_le4 = (r_rem <= 11'd4);
    assign w_keep    = w_rem_ge4 ? 4'b1111 : ((4'b0001 << r_rem[1:0]) - 4'b0001);
    assign w_take    = w_rem_ge4 ? 11'd4 : r_rem;

    always_ff @(posedge user_clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_load_desc    = 1'b0;
        w_data_step    = 1'b0;
        w_out_valid    = 1'b0;
        w_out_data     = '0;
        w_out_keep     = 4'b0000;
        w_out_last     = 1'b0;
        w_dec_err      = 1'b0;
        w_dec_err_tag  = r_cur_tag;
        w_dec_err_code = 4'd0;
        w_clr          = 1'b0;
        w_clr_tag      = r_cur_tag;
        case (r_state)
            ST_IDLE: begin
                if (w_beat) begin
                    if (w_desc_code != 4'd0) begin
                        w_dec_err      = 1'b1;
                        w_dec_err_tag  = w_desc_tag;
                        w_dec_err_code = w_desc_code;
                        w_state_nxt    = m_axis_rc_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        w_load_desc = 1'b1;
                        w_clr       = m_axis_rc_tlast && w_desc_req_cpl;
                        w_clr_tag   = w_desc_tag;
                        if (w_desc_dw_cnt == 11'd0)
                            w_state_nxt = ST_IDLE;
                        else if (m_axis_rc_tlast)
                            w_state_nxt = ST_FLUSH;
                        else
                            w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_beat) begin
                    w_out_valid = 1'b1;
                    w_out_data  = {m_axis_rc_tdata[95:0], r_held};
                    w_out_keep  = w_keep;
                    w_out_last  = w_rem_le4;
                    w_data_step = 1'b1;
                    if (m_axis_rc_tlast) begin
                        if (w_rem_le4 || r_rem == 11'd5) begin
                            w_clr       = r_cur_req_cpl;
                            w_state_nxt = w_rem_le4 ? ST_IDLE : ST_FLUSH;
                        end else begin
                            // Completion ended early: close the read with a forced last.
                            w_dec_err      = 1'b1;
                            w_dec_err_code = c_ERR_LENGTH;
                            w_out_last     = 1'b1;
                            w_state_nxt    = ST_IDLE;
                        end
                    end else if (w_rem_le4) begin
                        w_dec_err      = 1'b1;
                        w_dec_err_code = c_ERR_LENGTH;
                        w_state_nxt    = ST_DROP;
                    end
                end
            end
            ST_FLUSH: begin
                w_out_valid = 1'b1;
                w_out_data  = {96'd0, r_held};
                w_out_keep  = 4'b0001;
                w_out_last  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_DROP: begin
                if (w_beat && m_axis_rc_tlast)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            r_held        <= '0;
            r_rem         <= '0;
            r_cur_tag     <= '0;
            r_cur_req_cpl <= 1'b0;
        end else if (w_load_desc) begin
            r_held        <= m_axis_rc_tdata[127:96];
            r_rem         <= w_desc_dw_cnt;
            r_cur_tag     <= w_desc_tag;
            r_cur_req_cpl <= w_desc_req_cpl;
        end else if (w_data_step) begin
            r_held        <= m_axis_rc_tdata[127:96];
            r_rem         <= r_rem - w_take;
        end
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
            r_rd_keep  <= '0;
            r_rd_tag   <= '0;
        end else begin
            r_rd_valid <= w_out_valid;
            r_rd_last  <= w_out_valid && w_out_last;
            if (w_out_valid) begin
                r_rd_data <= w_out_data;
                r_rd_keep <= w_out_keep;
                r_rd_tag  <= r_cur_tag;
            end
        end
    end

    // A tag retired in the same cycle it is re-issued is a legal reuse, not a duplicate.
    assign w_dup     = req_issue_valid && r_bitmap[req_issue_tag] &&
                       !(w_clr && (w_clr_tag == req_issue_tag));
    assign w_set     = req_issue_valid && !w_dup;
    assign w_clr_eff = w_clr && r_bitmap[w_clr_tag] &&
                       !(w_set && (req_issue_tag == w_clr_tag));
    assign w_inc     = w_set && !r_bitmap[req_issue_tag];

    always_ff @(posedge user_clk) begin
        if (reset) begin
            r_bitmap <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_clr_eff)
                r_bitmap[w_clr_tag] <= 1'b0;
            if (w_set)
                r_bitmap[req_issue_tag] <= 1'b1;
            if (w_inc && !w_clr_eff)
                r_cnt <= r_cnt + 9'd1;
            else if (w_clr_eff && !w_inc)
                r_cnt <= r_cnt - 9'd1;
        end
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            r_err_valid <= 1'b0;
            r_err_tag   <= '0;
            r_err_code  <= '0;
        end else begin
            r_err_valid <= w_dec_err || w_dup;
            if (w_dec_err) begin
                r_err_tag  <= w_dec_err_tag;
                r_err_code <= w_dec_err_code;
            end else if (w_dup) begin
                r_err_tag  <= req_issue_tag;
                r_err_code <= c_ERR_DUP;
            end
        end
    end

    assign rd_valid        = r_rd_valid;
    assign rd_data         = r_rd_data;
    assign rd_keep         = r_rd_keep;
    assign rd_last         = r_rd_last;
    assign rd_tag          = r_rd_tag;
    assign cpl_err_valid   = r_err_valid;
    assign cpl_err_tag     = r_err_tag;
    assign cpl_err_code    = r_err_code;
    assign outstanding_cnt = r_cnt;
    assign idle            = (r_state == ST_IDLE) && (r_cnt == 9'd0);

endmodule
`default_nettype wire

// File: tb/tb_user_rc_decoder.sv
`default_nettype none
// Bench for user_rc_decoder: scoreboard of read beats and error pulses,
// plus direct checks of the outstanding counter, handshake and reset.
module tb_user_rc_decoder;

    logic           user_clk = 1'b0;
    logic           reset;
    logic [127:0]   m_axis_rc_tdata;
    logic [3:0]     m_axis_rc_tkeep;
    logic [74:0]    m_axis_rc_tuser;
    logic           m_axis_rc_tlast;
    logic           m_axis_rc_tvalid;
    logic           m_axis_rc_tready;
    logic           req_issue_valid;
    logic [7:0]     req_issue_tag;
    logic           rd_valid;
    logic [127:0]   rd_data;
    logic [3:0]     rd_keep;
    logic           rd_last;
    logic [7:0]     rd_tag;
    logic           cpl_err_valid;
    logic [7:0]     cpl_err_tag;
    logic [3:0]     cpl_err_code;
    logic [8:0]     outstanding_cnt;
    logic           idle;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   keep;
        logic         last;
        logic [7:0]   tag;
    } rd_exp_t;

    typedef struct packed {
        logic [7:0] tag;
        logic [3:0] code;
    } err_exp_t;

    rd_exp_t  rd_q[$];
    err_exp_t err_q[$];
    int checks = 0;
    int errors = 0;

    user_rc_decoder dut (
        .user_clk         (user_clk),
        .reset            (reset),
        .m_axis_rc_tdata  (m_axis_rc_tdata),
        .m_axis_rc_tkeep  (m_axis_rc_tkeep),
        .m_axis_rc_tuser  (m_axis_rc_tuser),
        .m_axis_rc_tlast  (m_axis_rc_tlast),
        .m_axis_rc_tvalid (m_axis_rc_tvalid),
        .m_axis_rc_tready (m_axis_rc_tready),
        .req_issue_valid  (req_issue_valid),
        .req_issue_tag    (req_issue_tag),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .rd_keep          (rd_keep),
        .rd_last          (rd_last),
        .rd_tag           (rd_tag),
        .cpl_err_valid    (cpl_err_valid),
        .cpl_err_tag      (cpl_err_tag),
        .cpl_err_code     (cpl_err_code),
        .outstanding_cnt  (outstanding_cnt),
        .idle             (idle)
    );

    always #5 user_clk = ~user_clk;

    always @(negedge user_clk) begin
        rd_exp_t  e;
        err_exp_t f;
        if (rd_valid === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got data=%h keep=%b last=%b tag=%h, required no output",
                         rd_data, rd_keep, rd_last, rd_tag);
            end else begin
                e = rd_q.pop_front();
                if ({rd_data, rd_keep, rd_last, rd_tag} !== {e.data, e.keep, e.last, e.tag}) begin
                    errors++;
                    $display("FAIL rd_beat: got data=%h keep=%b last=%b tag=%h, required data=%h keep=%b last=%b tag=%h",
                             rd_data, rd_keep, rd_last, rd_tag, e.data, e.keep, e.last, e.tag);
                end
            end
        end
        if (cpl_err_valid === 1'b1) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL err_unexpected: got tag=%h code=%0d, required no error", cpl_err_tag, cpl_err_code);
            end else begin
                f = err_q.pop_front();
                if ({cpl_err_tag, cpl_err_code} !== {f.tag, f.code}) begin
                    errors++;
                    $display("FAIL err_pulse: got tag=%h code=%0d, required tag=%h code=%0d",
                             cpl_err_tag, cpl_err_code, f.tag, f.code);
                end
            end
        end
    end

    function automatic logic [127:0] mk_desc(input logic [10:0] dwc, input logic [7:0] tag,
                                             input logic rc, input logic [2:0] st,
                                             input logic poison, input logic [3:0] ec,
                                             input logic [31:0] dw0);
        logic [127:0] d;
        d          = '0;
        d[42:32]   = dwc;
        d[45:43]   = st;
        d[46]      = poison;
        d[15:12]   = ec;
        d[30]      = rc;
        d[71:64]   = tag;
        d[127:96]  = dw0;
        return d;
    endfunction

    task automatic send_beat(input logic [127:0] d, input logic last, input logic [74:0] u);
        int guard;
        guard            = 0;
        m_axis_rc_tdata  = d;
        m_axis_rc_tuser  = u;
        m_axis_rc_tlast  = last;
        m_axis_rc_tvalid = 1'b1;
        while (m_axis_rc_tready !== 1'b1 && guard < 8) begin
            @(negedge user_clk);
            guard++;
        end
        if (m_axis_rc_tready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tready_stuck: got tready=%b, required 1 within 8 cycles", m_axis_rc_tready);
        end
        @(negedge user_clk);
        m_axis_rc_tvalid = 1'b0;
        m_axis_rc_tlast  = 1'b0;
    endtask

    task automatic issue(input logic [7:0] t);
        req_issue_valid = 1'b1;
        req_issue_tag   = t;
        @(negedge user_clk);
        req_issue_valid = 1'b0;
    endtask

    // Builds a well-formed completion of dwc dwords and queues the realigned reads it should produce.
    task automatic send_clean(input logic [7:0] tag, input int dwc, input logic rc,
                              input logic [31:0] seed, input logic iss_last, input logic [7:0] iss_tag);
        logic [31:0]  dw [64];
        logic [127:0] b;
        rd_exp_t      e;
        int           nbeats;
        int           nout;
        int           idx;
        for (int i = 0; i < 64; i++) dw[i] = seed + 32'(i);
        nout = (dwc + 3) / 4;
        for (int k = 0; k < nout; k++) begin
            e.data = '0;
            e.keep = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < dwc) begin
                    e.data[32*j +: 32] = dw[4*k+j];
                    e.keep[j]          = 1'b1;
                end
            end
            e.last = (k == nout - 1);
            e.tag  = tag;
            rd_q.push_back(e);
        end
        nbeats = 1 + (dwc + 2) / 4;
        for (int bi = 0; bi < nbeats; bi++) begin
            if (bi == 0) begin
                b = mk_desc(11'(dwc), tag, rc, 3'd0, 1'b0, 4'd0, dw[0]);
            end else begin
                b = '0;
                for (int j = 0; j < 4; j++) begin
                    idx = 4 * bi - 3 + j;
                    if (idx < dwc) b[32*j +: 32] = dw[idx];
                end
            end
            if (bi == nbeats - 1 && iss_last) begin
                req_issue_valid = 1'b1;
                req_issue_tag   = iss_tag;
            end
            send_beat(b, bi == nbeats - 1, '0);
            req_issue_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while ((rd_q.size() != 0 || err_q.size() != 0) && g < 40) begin
            @(negedge user_clk);
            g++;
        end
        repeat (3) @(negedge user_clk);
        checks++;
        if (rd_q.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got pending rd=%0d err=%0d, required 0 0", name, rd_q.size(), err_q.size());
        end
    endtask

    task automatic test_reset(input string name, input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge user_clk);
        reset = 1'b0;
        checks++;
        if ({rd_valid, rd_last, cpl_err_valid} !== 3'b000) begin
            errors++;
            $display("FAIL %s_flags: got valid/last/err=%b%b%b, required 000", name, rd_valid, rd_last, cpl_err_valid);
        end
        checks++;
        if (rd_data !== 128'd0 || rd_keep !== 4'd0 || rd_tag !== 8'd0) begin
            errors++;
            $display("FAIL %s_rd_fields: got data=%h keep=%b tag=%h, required zero", name, rd_data, rd_keep, rd_tag);
        end
        checks++;
        if ({cpl_err_tag, cpl_err_code} !== 12'h000) begin
            errors++;
            $display("FAIL %s_err_fields: got tag=%h code=%0d, required 0 0", name, cpl_err_tag, cpl_err_code);
        end
        checks++;
        if (outstanding_cnt !== 9'd0) begin
            errors++;
            $display("FAIL %s_cnt: got %0d, required 0", name, outstanding_cnt);
        end
        checks++;
        if (m_axis_rc_tready !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_idle: got tready=%b idle=%b, required 1 1", name, m_axis_rc_tready, idle);
        end
    endtask

    task automatic check_cnt(input string name, input logic [8:0] exp_cnt);
        checks++;
        if (outstanding_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s_cnt: got %0d, required %0d", name, outstanding_cnt, exp_cnt);
        end
    endtask

    task automatic test_single_dword();
        issue(8'h05);
        check_cnt("single_issue", 9'd1);
        checks++;
        if (idle !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got %b, required 0", idle);
        end
        send_clean(8'h05, 1, 1'b1, 32'hDEADBEEF, 1'b0, 8'h00);
        checks++;
        if (m_axis_rc_tready !== 1'b0) begin
            errors++;
            $display("FAIL single_flush_tready: got %b, required 0", m_axis_rc_tready);
        end
        check_cnt("single_retire", 9'd0);
        @(negedge user_clk);
        checks++;
        if (m_axis_rc_tready !== 1'b1) begin
            errors++;
            $display("FAIL single_tready_back: got %b, required 1", m_axis_rc_tready);
        end
        drain("single");
    endtask

    task automatic test_multi_beat();
        issue(8'h10);
        send_clean(8'h10, 8, 1'b1, 32'hA000_0000, 1'b0, 8'h00);
        drain("multi");
        check_cnt("multi", 9'd0);
    endtask

    task automatic test_split();
        issue(8'h20);
        send_clean(8'h20, 3, 1'b0, 32'hB000_0000, 1'b0, 8'h00);
        drain("split_a");
        check_cnt("split_partial", 9'd1);
        send_clean(8'h20, 2, 1'b1, 32'hB000_0003, 1'b0, 8'h00);
        drain("split_b");
        check_cnt("split_done", 9'd0);
    endtask

    task automatic test_unissued();
        err_q.push_back('{tag: 8'h33, code: 4'd4});
        send_beat(mk_desc(11'd8, 8'h33, 1'b1, 3'd0, 1'b0, 4'd0, 32'h1111_1111), 1'b0, '0);
        send_beat({4{32'h2222_2222}}, 1'b0, '0);
        send_beat({4{32'h3333_3333}}, 1'b1, '0);
        drain("unissued");
        check_cnt("unissued", 9'd0);
    endtask

    task automatic test_errors();
        logic [74:0] disc;
        disc     = '0;
        disc[42] = 1'b1;
        issue(8'h07);
        err_q.push_back('{tag: 8'h07, code: 4'd1});
        send_beat(mk_desc(11'd1, 8'h07, 1'b1, 3'b001, 1'b0, 4'd0, 32'h0), 1'b1, '0);
        err_q.push_back('{tag: 8'h07, code: 4'd1});
        send_beat(mk_desc(11'd1, 8'h07, 1'b1, 3'b010, 1'b1, 4'd0, 32'h0), 1'b1, '0);
        err_q.push_back('{tag: 8'h07, code: 4'd2});
        send_beat(mk_desc(11'd1, 8'h07, 1'b1, 3'd0, 1'b1, 4'h2, 32'h0), 1'b1, '0);
        err_q.push_back('{tag: 8'h07, code: 4'd3});
        send_beat(mk_desc(11'd1, 8'h07, 1'b1, 3'd0, 1'b0, 4'hA, 32'h0), 1'b1, disc);
        err_q.push_back('{tag: 8'h07, code: 4'd6});
        send_beat(mk_desc(11'd1, 8'h07, 1'b1, 3'd0, 1'b0, 4'd0, 32'h0), 1'b1, disc);
        err_q.push_back('{tag: 8'h33, code: 4'd4});
        send_beat(mk_desc(11'd1, 8'h33, 1'b1, 3'b001, 1'b0, 4'd0, 32'h0), 1'b1, '0);
        drain("err_desc");
        // Completion truncated: tlast on the second beat of an 8-dword read.
        rd_q.push_back('{data: {32'hC4, 32'hC3, 32'hC2, 32'hC1}, keep: 4'b1111, last: 1'b1, tag: 8'h07});
        err_q.push_back('{tag: 8'h07, code: 4'd5});
        send_beat(mk_desc(11'd8, 8'h07, 1'b1, 3'd0, 1'b0, 4'd0, 32'hC1), 1'b0, '0);
        send_beat({32'hC5, 32'hC4, 32'hC3, 32'hC2}, 1'b1, '0);
        drain("err_short");
        // Completion overrun: payload exhausted but no tlast.
        rd_q.push_back('{data: {32'h0, 32'h0, 32'hD2, 32'hD1}, keep: 4'b0011, last: 1'b1, tag: 8'h07});
        err_q.push_back('{tag: 8'h07, code: 4'd5});
        send_beat(mk_desc(11'd2, 8'h07, 1'b1, 3'd0, 1'b0, 4'd0, 32'hD1), 1'b0, '0);
        send_beat({32'h0, 32'h0, 32'h0, 32'hD2}, 1'b0, '0);
        send_beat({4{32'hEEEE_EEEE}}, 1'b1, '0);
        drain("err_long");
        check_cnt("errors", 9'd1);
    endtask

    task automatic test_dup_issue();
        err_q.push_back('{tag: 8'h07, code: 4'd7});
        issue(8'h07);
        drain("dup");
        check_cnt("dup", 9'd1);
    endtask

    task automatic test_back_to_back();
        issue(8'h50);
        issue(8'h51);
        check_cnt("b2b_issue", 9'd3);
        send_clean(8'h50, 6, 1'b1, 32'h5000_0000, 1'b0, 8'h00);
        send_clean(8'h51, 5, 1'b1, 32'h5100_0000, 1'b0, 8'h00);
        drain("b2b");
        check_cnt("b2b_done", 9'd1);
    endtask

    task automatic test_concurrent();
        issue(8'h02);
        check_cnt("conc_issue", 9'd2);
        send_clean(8'h02, 4, 1'b1, 32'h0200_0000, 1'b1, 8'h01);
        check_cnt("conc_swap", 9'd2);
        drain("conc_a");
        send_clean(8'h01, 1, 1'b1, 32'h0100_0000, 1'b1, 8'h01);
        check_cnt("conc_same_tag", 9'd2);
        drain("conc_b");
        send_clean(8'h01, 1, 1'b1, 32'h0100_0010, 1'b0, 8'h00);
        drain("conc_c");
        check_cnt("conc_reuse", 9'd1);
    endtask

    task automatic test_reset_mid();
        issue(8'h40);
        rd_q.push_back('{data: {32'h43, 32'h42, 32'h41, 32'h40}, keep: 4'b1111, last: 1'b0, tag: 8'h40});
        send_beat(mk_desc(11'd8, 8'h40, 1'b1, 3'd0, 1'b0, 4'd0, 32'h40), 1'b0, '0);
        send_beat({32'h44, 32'h43, 32'h42, 32'h41}, 1'b0, '0);
        test_reset("reset_mid", 1);
        drain("reset_mid");
        issue(8'h41);
        send_clean(8'h41, 2, 1'b1, 32'h4100_0000, 1'b0, 8'h00);
        drain("post_reset");
        check_cnt("post_reset", 9'd0);
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: got %b, required 1", idle);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        m_axis_rc_tdata  = '0;
        m_axis_rc_tkeep  = 4'hF;
        m_axis_rc_tuser  = '0;
        m_axis_rc_tlast  = 1'b0;
        m_axis_rc_tvalid = 1'b0;
        req_issue_valid  = 1'b0;
        req_issue_tag    = '0;
        test_reset("reset", 3);
        test_single_dword();
        test_multi_beat();
        test_split();
        test_unissued();
        test_errors();
        test_dup_issue();
        test_back_to_back();
        test_concurrent();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
